// File: rtl/timer_device.sv
// rtl/timer_device.sv - memory-mapped down-counting timer with load/count/irq FSM
module timer_device #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dev_sel,
    input  logic        dev_we,
    input  logic [1:0]  dev_addr,
    input  logic [31:0] dev_wdata,
    output logic [31:0] dev_rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_IRQ   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             en;
    logic             im;
    logic [1:0]       mode;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             pending;
    logic             pend_set;
    logic             hw_clear_en;
    logic             wr_ctrl;
    logic             wr_preset;
    logic [31:0]      preset_ext;
    logic [31:0]      count_ext;

    assign wr_ctrl   = dev_sel & dev_we & (dev_addr == 2'd0);
    assign wr_preset = dev_sel & dev_we & (dev_addr == 2'd1);

    always_comb begin
        state_next  = state;
        count_next  = count;
        pend_set    = 1'b0;
        hw_clear_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                count_next = preset;
                state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (count <= CNT_W'(1)) begin
                    count_next = '0;
                    pend_set   = 1'b1;
                    state_next = ST_IRQ;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            ST_IRQ: begin
                // Only MODE==01 reloads; MODE 1x behaves as one-shot.
                if (mode == 2'b01 && en) begin
                    state_next = ST_LOAD;
                end else begin
                    state_next  = ST_IDLE;
                    hw_clear_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            en      <= 1'b0;
            mode    <= 2'b00;
            im      <= 1'b0;
            preset  <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            // A CPU write to CTRL wins over the hardware EN clear.
            if (wr_ctrl) begin
                en   <= dev_wdata[0];
                mode <= dev_wdata[2:1];
                im   <= dev_wdata[3];
            end else if (hw_clear_en) begin
                en <= 1'b0;
            end
            if (wr_preset) preset <= dev_wdata[CNT_W-1:0];
            if (pend_set) begin
                pending <= 1'b1;
            end else if (wr_ctrl || wr_preset) begin
                pending <= 1'b0;
            end
        end
    end

    assign irq = pending & im;

    always_comb begin
        preset_ext             = '0;
        preset_ext[CNT_W-1:0]  = preset;
        count_ext              = '0;
        count_ext[CNT_W-1:0]   = count;
    end

    always_comb begin
        dev_rdata = '0;
        if (dev_sel) begin
            case (dev_addr)
                2'd0:    dev_rdata = {28'd0, im, mode, en};
                2'd1:    dev_rdata = preset_ext;
                2'd2:    dev_rdata = count_ext;
                default: dev_rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Programmable down-counting timer.
- Acts as a memory-mapped responder on the CPU device bus: the CPU drives DEVICE_WE, DEVICE_ADDR and DEVICE_DATA, and reads back through DEVICE_OUT.
- Decodes register accesses, runs a load/count/interrupt FSM, and drives one bit of the CPU HW_INT vector.
- Sits behind the system bridge, which supplies the chip select and returns dev_rdata as DEVICE_OUT.

Parameters:
- CNT_W, 32: width of the PRESET and COUNT registers (1..32). Upper read bits are zero when CNT_W<32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk).
- dev_sel  input  1  bridge chip select for this device.
- dev_we  input  1  write strobe (DEVICE_WE); effective only with dev_sel=1.
- dev_addr  input  2  word offset, DEVICE_ADDR[3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- dev_wdata  input  32  write data (DEVICE_DATA).
- dev_rdata  output  32  read data to bridge/DEVICE_OUT.
- irq  output  1  interrupt request to one HW_INT bit, level, active-high.

Behaviour:
- Registers
  - CTRL[0] EN: enable. CTRL[2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00 but read back as written. CTRL[3] IM: interrupt mask, 1 = irq enabled. CTRL[31:4] read 0.
  - PRESET: read/write, low CNT_W bits stored.
  - COUNT: read-only; writes to it are ignored.
  - Offset 3: reads 0, writes ignored.
- Reset (reset==0 at an edge)
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0.
  - Hence irq=0 and dev_rdata=0 when dev_sel=0.
  - Reset applies mid-count and overrides any simultaneous write.
- Reads
  - Combinational, zero wait states: dev_rdata = register selected by dev_addr when dev_sel=1, else 0.
- Writes
  - Take effect at the next edge when dev_sel & dev_we. No wait states.
  - Any write to CTRL or PRESET clears pending at that edge.
  - If the FSM sets pending on the same edge, the set wins.
- FSM (state updated every edge)
  - IDLE: if EN=1, go to LOAD. COUNT holds its value.
  - LOAD: COUNT <= PRESET; go to COUNT.
  - COUNT:
    - If EN=0: go to IDLE, COUNT holds.
    - Else if COUNT<=1: COUNT <= 0, pending <= 1, go to IRQ.
    - Else: COUNT <= COUNT-1.
    - PRESET=0 therefore reaches IRQ one edge after LOAD.
  - IRQ:
    - MODE=01 and EN=1: go to LOAD.
    - Otherwise: go to IDLE and clear EN in hardware.
    - If the CPU writes CTRL on this same edge, the written value wins over the hardware clear.
  - EN sampled in the FSM is the current registered CTRL[0]. A CTRL write updates EN at edge T; the FSM reacts at edge T+1.
  - Writing PRESET during counting does not alter COUNT until the next LOAD.
- Interrupt
  - irq = pending & IM, registered-derived with no combinational path from bus inputs.
  - pending is sticky across reloads until a CTRL/PRESET write.
  - Clearing IM masks irq without clearing pending.
- Timing
  - CTRL write enabling at edge 0 with PRESET=N (N≥1): LOAD at edge 1, COUNT=N at edge 2, irq rises after edge N+2.
  - Auto-reload period is N+2 cycles.

Test Plan:
- Reset: hold reset=0 for 2 cycles with dev_sel=1, dev_we=1, dev_wdata=0xFFFFFFFF → all registers read 0, irq=0.
- One-shot: PRESET=5, then write CTRL=0x9 at edge 0 → COUNT reads 5,4,3,2,1 after edges 2..6. COUNT=0 and irq=1 after edge 7. CTRL reads 0x8 after edge 8. irq stays 1 until PRESET is written, then 0 the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → irq rises after edge 5. COUNT reloads to 3 at edge 7. Next IRQ state at edge 10. After a CTRL=0xB rewrite clears pending, irq rises again at the following period boundary.
- Mask/disable: CTRL=0x1 (IM=0), PRESET=2 → irq stays 0, pending observed by later setting IM=1 via CTRL=0x9 … which also clears pending, so irq stays 0. Writing CTRL=0x0 mid-count freezes COUNT at its current value.
- Boundaries: PRESET=0 with CTRL=0x9 → irq after edge 3. Reads at offsets 2 and 3 with dev_sel=0 return 0. A write to COUNT (offset 2) leaves COUNT unchanged.
- Reset mid-operation: assert reset=0 while COUNT=2 and pending=1 → next cycle COUNT=0, irq=0, state idle, and no further IRQ without reprogramming.
